// File: rtl/sync_frame_tx_1011.sv
// Serialises a DATA_W payload behind a 1,0,1,1 sync word, MSB first, one bit per clock.
// Define SYNC_FRAME_TX_PARITY_EN to append an even-parity bit after the payload LSB.
module sync_frame_tx_1011 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_done,
    output logic              busy
);
    // The counter indexes both the four sync bits and the payload bits.
    localparam int CNT_W = ($clog2(DATA_W) > 2) ? $clog2(DATA_W) : 2;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       SYNC_WORD = 4'b1011;

`ifdef SYNC_FRAME_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [DATA_W-1:0]  shift_reg;
    logic               tx_bit_reg;
    logic               tx_valid_reg;
    logic               tx_done_reg;
    logic               accept;

`ifdef SYNC_FRAME_TX_PARITY_EN
    logic [DATA_W:0]    par_chain;
    logic               parity_reg;

    assign par_chain[0] = 1'b0;
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_par
        assign par_chain[gi+1] = par_chain[gi] ^ in_data[gi];
    end
`endif

    // The final frame bit always carries tx_done, so it doubles as the "can restart" flag.
    assign in_ready = rst && ((state_reg == IDLE) || tx_done_reg);
    assign busy     = rst && (state_reg != IDLE);
    assign accept   = in_valid && in_ready;
    assign tx_bit   = tx_bit_reg;
    assign tx_valid = tx_valid_reg;
    assign tx_done  = tx_done_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            shift_reg    <= '0;
            tx_bit_reg   <= 1'b0;
            tx_valid_reg <= 1'b0;
            tx_done_reg  <= 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else if ((state_reg == IDLE) || tx_done_reg) begin
            tx_done_reg <= 1'b0;
            cnt_reg     <= '0;
            if (accept) begin
                state_reg    <= SYNC;
                shift_reg    <= in_data;
                tx_bit_reg   <= SYNC_WORD[3];
                tx_valid_reg <= 1'b1;
`ifdef SYNC_FRAME_TX_PARITY_EN
                parity_reg   <= par_chain[DATA_W];
`endif
            end else begin
                state_reg    <= IDLE;
                tx_bit_reg   <= 1'b0;
                tx_valid_reg <= 1'b0;
            end
        end else begin
            case (state_reg)
                SYNC: begin
                    if (cnt_reg == LAST_SYNC) begin
                        state_reg  <= DATA;
                        cnt_reg    <= '0;
                        tx_bit_reg <= shift_reg[DATA_W-1];
                        shift_reg  <= {shift_reg[DATA_W-2:0], 1'b0};
                    end else begin
                        cnt_reg    <= cnt_reg + CNT_ONE;
                        tx_bit_reg <= SYNC_WORD[2'd2 - cnt_reg[1:0]];
                    end
                end
                DATA: begin
                    if (cnt_reg == LAST_DATA) begin
`ifdef SYNC_FRAME_TX_PARITY_EN
                        state_reg   <= PARITY;
                        tx_bit_reg  <= parity_reg;
                        tx_done_reg <= 1'b1;
`endif
                    end else begin
                        cnt_reg    <= cnt_reg + CNT_ONE;
                        tx_bit_reg <= shift_reg[DATA_W-1];
                        shift_reg  <= {shift_reg[DATA_W-2:0], 1'b0};
`ifndef SYNC_FRAME_TX_PARITY_EN
                        tx_done_reg <= ((cnt_reg + CNT_ONE) == LAST_DATA);
`endif
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    tx_valid_reg <= 1'b0;
                    tx_bit_reg   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sync_frame_tx_1011.sv
// Scoreboard bench for sync_frame_tx_1011: an 8-bit and a 4-bit instance checked every clock.
// Frames are queued from a reference model at acceptance and popped as tx_valid bits appear.
module tb_sync_frame_tx_1011;
`ifdef SYNC_FRAME_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LEN8 = 4 + 8 + PAR;
    localparam int LEN4 = 4 + 4 + PAR;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d8;
    logic       v8;
    logic       r8, tb8, tv8, td8, b8;
    logic [3:0] d4;
    logic       v4;
    logic       r4, tb4, tv4, td4, b4;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] q8[$];
    logic [1:0] q4[$];
    int         rem8 = 0;
    int         rem4 = 0;
    logic       acc8 = 1'b0;
    logic       acc4 = 1'b0;
    int         run8 = 0;
    int         run_max8 = 0;

    always #5 clk = ~clk;

    sync_frame_tx_1011 #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_data(d8), .in_valid(v8), .in_ready(r8),
        .tx_bit(tb8), .tx_valid(tv8), .tx_done(td8), .busy(b8)
    );

    sync_frame_tx_1011 #(.DATA_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_data(d4), .in_valid(v4), .in_ready(r4),
        .tx_bit(tb4), .tx_valid(tv4), .tx_done(td4), .busy(b4)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference frame: sync 1011, payload MSB first, optional even parity.
    function automatic logic frame_bit(input int w, input logic [31:0] d, input int i);
        logic [3:0]  sw;
        logic [31:0] mask;
        sw   = 4'b1011;
        mask = (32'd1 << w) - 32'd1;
        if (i < 4) return sw[3-i];
        if (i < 4 + w) return d[w-1-(i-4)];
        return ^(d & mask);
    endfunction

    task automatic chk_dut(input string p, input int rem, input logic [1:0] e,
                           input logic rdy, input logic bsy, input logic tv,
                           input logic tbit, input logic td);
        check({p, "_in_ready"}, 32'(rdy), 32'(rst && (rem <= 1)));
        check({p, "_busy"}, 32'(bsy), 32'(rst && (rem > 0)));
        check({p, "_tx_valid"}, 32'(tv), 32'(rem > 0));
        check({p, "_tx_bit"}, 32'(tbit), 32'(e[1]));
        check({p, "_tx_done"}, 32'(td), 32'(e[0]));
    endtask

    // One clock: update the model at the edge, then check both DUTs on the falling edge.
    task automatic cycle();
        logic [1:0] e;
        @(posedge clk);
        acc8 = rst && v8 && (rem8 <= 1);
        acc4 = rst && v4 && (rem4 <= 1);
        if (!rst) begin
            rem8 = 0; rem4 = 0;
            q8.delete(); q4.delete();
        end else begin
            if (acc8) begin
                for (int i = 0; i < LEN8; i++) q8.push_back({frame_bit(8, 32'(d8), i), 1'(i == LEN8 - 1)});
                rem8 = LEN8;
            end else if (rem8 > 0) rem8--;
            if (acc4) begin
                for (int i = 0; i < LEN4; i++) q4.push_back({frame_bit(4, 32'(d4), i), 1'(i == LEN4 - 1)});
                rem4 = LEN4;
            end else if (rem4 > 0) rem4--;
        end
        @(negedge clk);
        if (rem8 > 0) e = (q8.size() > 0) ? q8.pop_front() : 2'bxx;
        else e = 2'b00;
        chk_dut($sformatf("w8_t%0t", $time), rem8, e, r8, b8, tv8, tb8, td8);
        if (rem4 > 0) e = (q4.size() > 0) ? q4.pop_front() : 2'bxx;
        else e = 2'b00;
        chk_dut($sformatf("w4_t%0t", $time), rem4, e, r4, b4, tv4, tb4, td4);
        run8 = tv8 ? run8 + 1 : 0;
        if (run8 > run_max8) run_max8 = run8;
    endtask

    task automatic send8(input logic [7:0] d);
        v8 = 1'b1;
        d8 = d;
        for (int k = 0; k < 64; k++) begin
            cycle();
            if (acc8) break;
        end
        v8 = 1'b0;
        d8 = 8'($urandom);
    endtask

    initial begin
        rst = 1'b0; v8 = 1'b0; v4 = 1'b0; d8 = 8'h00; d4 = 4'h0;
        repeat (3) cycle();
        rst = 1'b1;
        cycle();

        // Single frames: A5 and 07 (parity value depends on build).
        send8(8'hA5);
        repeat (LEN8 + 1) cycle();
        send8(8'h07);
        repeat (LEN8 + 1) cycle();

        // Back-to-back FF then 00 with valid held across the final-bit cycle.
        run_max8 = 0;
        send8(8'hFF);
        send8(8'h00);
        repeat (LEN8 + 2) cycle();
        check("b2b_contig_valid", 32'(run_max8), 32'(2 * LEN8));

        // Payload toggles while busy; only the final-bit cycle may take the next one.
        send8(8'h5A);
        v8 = 1'b1;
        for (int k = 0; k < 64; k++) begin
            d8 = 8'($urandom);
            cycle();
            if (acc8) break;
        end
        v8 = 1'b0;
        repeat (LEN8 + 1) cycle();

        // Reset while DATA bit 3 of 3C is on the line, then a clean 81 frame.
        send8(8'h3C);
        repeat (7) cycle();
        rst = 1'b0;
        cycle();
        check("rst_abort_tx_valid", 32'(tv8), 32'd0);
        check("rst_abort_busy", 32'(b8), 32'd0);
        rst = 1'b1;
        cycle();
        send8(8'h81);
        repeat (LEN8 + 1) cycle();

        // Narrow instance: 4'hB.
        v4 = 1'b1;
        d4 = 4'hB;
        cycle();
        v4 = 1'b0;
        d4 = 4'h0;
        repeat (LEN4 + 1) cycle();

        // A few random payloads with random gaps.
        for (int k = 0; k < 4; k++) begin
            send8(8'($urandom));
            repeat ($urandom_range(0, LEN8 + 2)) cycle();
        end
        repeat (LEN8 + 1) cycle();
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sync_frame_tx_1011.md
SYNC_FRAME_TX_1011 -- requirements
Module: sync_frame_tx_1011

Interface
REQ-001 SHALL have parameter: DATA_W, 8, payload width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all logic updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_data  input  DATA_W  parallel payload to transmit.
REQ-005 SHALL have port: in_valid  input  1  payload offered.
REQ-006 SHALL have port: in_ready  output  1  block accepts payload this cycle.
REQ-007 SHALL have port: tx_bit  output  1  serial line bit, registered.
REQ-008 SHALL have port: tx_valid  output  1  tx_bit carries a frame bit this cycle, registered.
REQ-009 SHALL have port: tx_done  output  1  one-cycle pulse coincident with last frame bit, registered.
REQ-010 SHALL have port: busy  output  1  frame in progress (state not IDLE).

Function
REQ-011 SHALL implement FSM states IDLE, SYNC, DATA, and PARITY (PARITY only when PARITY_EN defined).
REQ-012 SHALL accept a payload on a rising edge where in_valid=1 and in_ready=1, latching in_data into an internal shift register.
REQ-013 SHALL drive in_ready=1 in IDLE and in the cycle the final frame bit is on tx_bit, otherwise 0.
REQ-014 SHALL present the first sync bit on tx_bit/tx_valid in the cycle immediately after acceptance (latency 1 clock).
REQ-015 SHALL emit the sync pattern 1,0,1,1 (one bit per clock, in that order) in SYNC.
REQ-016 SHALL then emit the DATA_W payload bits MSB first in DATA, one per clock, with no gap after the last sync bit.
REQ-017 SHALL, with PARITY_EN, emit one even-parity bit (XOR of all payload bits) after the payload LSB.
REQ-018 SHALL yield frame length 4+DATA_W clocks without PARITY_EN, 5+DATA_W with it; tx_valid=1 for every frame bit.
REQ-019 SHALL pulse tx_done=1 for exactly the final frame bit cycle.
REQ-020 SHALL, when a payload is accepted during the final-bit cycle, start the next frame's first sync bit on the following clock (back-to-back, no idle bit).
REQ-021 SHALL otherwise return to IDLE after the final bit, driving tx_bit=0, tx_valid=0.
REQ-022 SHALL ignore in_valid and in_data while in_ready=0; changes to in_data after acceptance SHALL NOT affect the frame in flight.
REQ-023 SHALL use a bit counter wide enough for DATA_W-1 and SHALL NOT wrap or skip bits for any legal DATA_W.

Reset
REQ-024 SHALL, on a rising edge with rst=0, enter IDLE and clear tx_bit=0, tx_valid=0, tx_done=0, bit counter=0, shift register=0.
REQ-025 SHALL hold in_ready=0 and busy=0 while rst=0.
REQ-026 SHALL abort any frame in progress on reset, with no further frame bits emitted; the first cycle after release SHALL have in_ready=1.

Configuration
REQ-027 SHALL compile in the PARITY state and trailing parity bit only when macro SYNC_FRAME_TX_PARITY_EN is defined.
REQ-028 SHALL, without SYNC_FRAME_TX_PARITY_EN, go directly from the last payload bit to end-of-frame; tx_done on payload LSB.

Verification
REQ-029 SHALL check single frame: DATA_W=8, in_data=8'hA5 accepted -> tx_bit 1,0,1,1,1,0,1,0,0,1,0,1 over 12 clocks, tx_done on 12th; with parity, 13th bit 0.
REQ-030 SHALL check parity: in_data=8'h07 with SYNC_FRAME_TX_PARITY_EN -> parity bit 1, frame 13 clocks, tx_done on 13th.
REQ-031 SHALL check back-to-back: 8'hFF then 8'h00 with in_valid held -> 24 (no parity) contiguous tx_valid=1 clocks, sync 1011 at clocks 1-4 and 13-16.
REQ-032 SHALL check mid-frame reset: rst=0 at DATA bit 3 of 8'h3C -> next clock tx_valid=0, busy=0; after release in_ready=1, new frame 8'h81 correct.
REQ-033 SHALL check busy-time stimulus: in_data toggled and in_valid=1 during frame of 8'h5A -> frame bits unchanged, second payload accepted only at final-bit cycle.
REQ-034 SHALL check DATA_W=4: in_data=4'hB -> tx_bit 1,0,1,1,1,0,1,1, tx_done on 8th clock (no parity).
